// File: rtl/weight_read_sequencer_pkg.sv
// Shared definitions for the neuron-level blocks: sequencer state encoding and
// the default activation/weight and weight-memory address widths.
package weight_read_sequencer_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/weight_read_sequencer_align_pipe.sv
// Single-stage register for a valid/data/first/last beat, used to line data up
// with a memory that returns its read one cycle after the request.
module weight_read_sequencer_align_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_first,
    output logic             out_last
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             first_q, first_d;
    logic             last_q, last_d;

    // NOTE: the data register only loads on a valid beat, so the output holds
    // its last value through bubbles; the markers are qualified by valid.
    always_comb begin
        valid_d = in_valid;
        first_d = in_valid & in_first;
        last_d  = in_valid & in_last;
        data_d  = in_valid ? in_data : data_q;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_first = first_q;
    assign out_last  = last_q;

endmodule

// File: rtl/weight_read_sequencer.sv
// Per-neuron weight read sequencer: accepts one activation per cycle, reads the
// matching weight and presents the aligned (activation, weight) pair to the MAC.
module weight_read_sequencer
    import weight_read_sequencer_pkg::*;
#(
    parameter int numWeight    = 784,
    parameter int addressWidth = ADDR_WIDTH_DEF,
    parameter int dataWidth    = DATA_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [dataWidth-1:0]    in_data,
    output logic                    in_ready,
    output logic                    ren,
    output logic [addressWidth:0]   raddr,
    input  logic [dataWidth-1:0]    wout,
    output logic                    mac_valid,
    output logic [dataWidth-1:0]    mac_x,
    output logic [dataWidth-1:0]    mac_w,
    output logic                    mac_first,
    output logic                    mac_last,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = addressWidth + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(numWeight - 1);

    generate
        if (numWeight < 1 || numWeight > (1 << addressWidth)) begin : g_bad_num_weight
            $error("weight_read_sequencer: numWeight must be in 1..2**addressWidth");
        end
    endgenerate

    seq_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           accept;
    logic           v_d;
    logic           first_d;
    logic           last_d;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        ren      = 1'b0;
        accept   = 1'b0;
        v_d      = 1'b0;
        first_d  = 1'b0;
        last_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    ren     = 1'b1;
                    v_d     = 1'b1;
                    first_d = (cnt_q == '0);
                    last_d  = (cnt_q == LAST_IDX);
                    // The counter stops on the last index rather than wrapping.
                    if (last_d) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign raddr = cnt_q;

    // The activation is delayed by the memory read latency so it meets wout.
    weight_read_sequencer_align_pipe #(
        .WIDTH (dataWidth)
    ) u_align_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v_d),
        .in_data   (in_data),
        .in_first  (first_d),
        .in_last   (last_d),
        .out_valid (mac_valid),
        .out_data  (mac_x),
        .out_first (mac_first),
        .out_last  (mac_last)
    );

    assign mac_w = wout;

endmodule
